// File: rtl/gjk_pkg.sv
// Shared definitions for the GJK Minkowski support-point controller.
//   COORD_W : vertex / position coordinate width (signed)
//   DIR_W   : search direction component width (signed)
//   PROJ_W  : width of a single-shape projection (sum of two products)
//   NVERT   : vertices per shape
package gjk_pkg;

  localparam int COORD_W = 19;
  localparam int DIR_W   = 10;
  localparam int PROJ_W  = 29;
  localparam int NVERT   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN_A = 2'd1,
    SCAN_B = 2'd2,
    OUT    = 2'd3
  } state_e;

  // -(-512) does not fit in DIR_W bits, so the most negative value clamps
  // to the most positive one instead of wrapping back onto itself.
  function automatic logic [DIR_W-1:0] sat_neg(input logic [DIR_W-1:0] v);
    logic [DIR_W-1:0] r;
    if (v == {1'b1, {(DIR_W-1){1'b0}}}) begin
      r = {1'b0, {(DIR_W-1){1'b1}}};
    end else begin
      r = -v;
    end
    return r;
  endfunction

endpackage

// File: rtl/support_scan.sv
// Single-shape support scan: evaluates one vertex per cycle for NVERT
// cycles and keeps the vertex with the largest projection (v - pos) . dir.
// Ties keep the lowest index.
//   clk, rst         : clock, synchronous active-high reset
//   start            : first scan cycle; vertex 0 is evaluated in this cycle
//   vx, vy           : flattened signed vertices, vertex i at [19i+18:19i]
//   pos_x, pos_y     : shape reference position
//   dir_x, dir_y     : search direction
//   done             : high in the cycle the last vertex is evaluated
//   best_x, best_y   : best vertex so far (final one cycle after done)
//   best_proj        : projection of the best vertex
module support_scan
  import gjk_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NVERT*COORD_W-1:0] vx,
  input  logic [NVERT*COORD_W-1:0] vy,
  input  logic [COORD_W-1:0]       pos_x,
  input  logic [COORD_W-1:0]       pos_y,
  input  logic [DIR_W-1:0]         dir_x,
  input  logic [DIR_W-1:0]         dir_y,
  output logic                     done,
  output logic [COORD_W-1:0]       best_x,
  output logic [COORD_W-1:0]       best_y,
  output logic [PROJ_W-1:0]        best_proj
);

  localparam logic [1:0] LAST_IDX = 2'(NVERT - 1);

  logic [1:0]                idx_q, idx_d, cur_idx;
  logic                      busy_q, busy_d;
  logic                      active, take;
  logic [COORD_W-1:0]        v_x, v_y;
  logic signed [COORD_W:0]   diff_x, diff_y;
  logic signed [PROJ_W-1:0]  px, py, proj;
  logic [COORD_W-1:0]        best_x_q, best_x_d, best_y_q, best_y_d;
  logic signed [PROJ_W-1:0]  best_proj_q, best_proj_d;

  assign active  = start | busy_q;
  assign cur_idx = start ? 2'd0 : idx_q;
  assign done    = active && (cur_idx == LAST_IDX);

  always_comb begin
    v_x    = vx[COORD_W*int'(cur_idx) +: COORD_W];
    v_y    = vy[COORD_W*int'(cur_idx) +: COORD_W];
    diff_x = $signed({v_x[COORD_W-1], v_x}) - $signed({pos_x[COORD_W-1], pos_x});
    diff_y = $signed({v_y[COORD_W-1], v_y}) - $signed({pos_y[COORD_W-1], pos_y});
    px     = PROJ_W'(diff_x) * PROJ_W'($signed(dir_x));
    py     = PROJ_W'(diff_y) * PROJ_W'($signed(dir_y));
    proj   = px + py;
    take   = (cur_idx == 2'd0) || (proj > best_proj_q);
  end

  always_comb begin
    idx_d       = idx_q;
    busy_d      = busy_q;
    best_x_d    = best_x_q;
    best_y_d    = best_y_q;
    best_proj_d = best_proj_q;
    if (active) begin
      idx_d  = cur_idx + 2'd1;
      busy_d = (cur_idx != LAST_IDX);
      if (take) begin
        best_x_d    = v_x;
        best_y_d    = v_y;
        best_proj_d = proj;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      busy_q      <= 1'b0;
      best_x_q    <= '0;
      best_y_q    <= '0;
      best_proj_q <= '0;
    end else begin
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      best_x_q    <= best_x_d;
      best_y_q    <= best_y_d;
      best_proj_q <= best_proj_d;
    end
  end

  assign best_x    = best_x_q;
  assign best_y    = best_y_q;
  assign best_proj = best_proj_q;

endmodule

// File: rtl/minkowski_support_ctrl.sv
// GJK Minkowski-difference support point sequencer. Scans shape A along d,
// then shape B along -d on one shared support_scan, and returns
// bestA - bestB with projA + projB.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   a_vx, a_vy, a_pos_* : shape A vertices (flattened) and position
//   b_vx, b_vy, b_pos_* : shape B vertices (flattened) and position
//   dir_x, dir_y        : search direction
//   res_valid/res_ready : result handshake
//   res_x, res_y        : bestA - bestB (20-bit signed)
//   res_proj            : projA + projB (30-bit signed)
//   query_cnt           : completed result handshakes, wrapping
//
// state  | meaning
// IDLE   | waiting for a request; request inputs are latched on acceptance
// SCAN_A | scanning shape A along d, one vertex per cycle
// SCAN_B | scanning shape B along sat_neg(d); first cycle saves A's result
// OUT    | result presented and held until res_ready
module minkowski_support_ctrl
  import gjk_pkg::*;
#(
  parameter int NVERT = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NVERT*COORD_W-1:0] a_vx,
  input  logic [NVERT*COORD_W-1:0] a_vy,
  input  logic [COORD_W-1:0]       a_pos_x,
  input  logic [COORD_W-1:0]       a_pos_y,
  input  logic [NVERT*COORD_W-1:0] b_vx,
  input  logic [NVERT*COORD_W-1:0] b_vy,
  input  logic [COORD_W-1:0]       b_pos_x,
  input  logic [COORD_W-1:0]       b_pos_y,
  input  logic [DIR_W-1:0]         dir_x,
  input  logic [DIR_W-1:0]         dir_y,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [COORD_W:0]         res_x,
  output logic [COORD_W:0]         res_y,
  output logic [PROJ_W:0]          res_proj,
  output logic [CNT_W-1:0]         query_cnt
);

  state_e                   state_q, state_d;
  logic                     start_q, start_d;
  logic [NVERT*COORD_W-1:0] a_vx_q, a_vx_d, a_vy_q, a_vy_d;
  logic [NVERT*COORD_W-1:0] b_vx_q, b_vx_d, b_vy_q, b_vy_d;
  logic [COORD_W-1:0]       a_pos_x_q, a_pos_x_d, a_pos_y_q, a_pos_y_d;
  logic [COORD_W-1:0]       b_pos_x_q, b_pos_x_d, b_pos_y_q, b_pos_y_d;
  logic [DIR_W-1:0]         dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [COORD_W-1:0]       besta_x_q, besta_x_d, besta_y_q, besta_y_d;
  logic [PROJ_W-1:0]        besta_proj_q, besta_proj_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     scan_b_sel;
  logic [NVERT*COORD_W-1:0] scan_vx, scan_vy;
  logic [COORD_W-1:0]       scan_pos_x, scan_pos_y;
  logic [DIR_W-1:0]         scan_dir_x, scan_dir_y;
  logic                     scan_done;
  logic [COORD_W-1:0]       scan_best_x, scan_best_y;
  logic [PROJ_W-1:0]        scan_best_proj;

  assign scan_b_sel = (state_q == SCAN_B);
  assign scan_vx    = scan_b_sel ? b_vx_q    : a_vx_q;
  assign scan_vy    = scan_b_sel ? b_vy_q    : a_vy_q;
  assign scan_pos_x = scan_b_sel ? b_pos_x_q : a_pos_x_q;
  assign scan_pos_y = scan_b_sel ? b_pos_y_q : a_pos_y_q;
  assign scan_dir_x = scan_b_sel ? sat_neg(dir_x_q) : dir_x_q;
  assign scan_dir_y = scan_b_sel ? sat_neg(dir_y_q) : dir_y_q;

  support_scan u_scan (
    .clk       (clk),
    .rst       (rst),
    .start     (start_q),
    .vx        (scan_vx),
    .vy        (scan_vy),
    .pos_x     (scan_pos_x),
    .pos_y     (scan_pos_y),
    .dir_x     (scan_dir_x),
    .dir_y     (scan_dir_y),
    .done      (scan_done),
    .best_x    (scan_best_x),
    .best_y    (scan_best_y),
    .best_proj (scan_best_proj)
  );

  always_comb begin
    state_d      = state_q;
    start_d      = 1'b0;
    a_vx_d       = a_vx_q;
    a_vy_d       = a_vy_q;
    b_vx_d       = b_vx_q;
    b_vy_d       = b_vy_q;
    a_pos_x_d    = a_pos_x_q;
    a_pos_y_d    = a_pos_y_q;
    b_pos_x_d    = b_pos_x_q;
    b_pos_y_d    = b_pos_y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    besta_x_d    = besta_x_q;
    besta_y_d    = besta_y_q;
    besta_proj_d = besta_proj_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_vx_d    = a_vx;
          a_vy_d    = a_vy;
          b_vx_d    = b_vx;
          b_vy_d    = b_vy;
          a_pos_x_d = a_pos_x;
          a_pos_y_d = a_pos_y;
          b_pos_x_d = b_pos_x;
          b_pos_y_d = b_pos_y;
          dir_x_d   = dir_x;
          dir_y_d   = dir_y;
          start_d   = 1'b1;
          state_d   = SCAN_A;
        end
      end
      SCAN_A: begin
        if (scan_done) begin
          start_d = 1'b1;
          state_d = SCAN_B;
        end
      end
      SCAN_B: begin
        // The scan registers still hold A's final result during B's first
        // cycle; they are overwritten at the end of it.
        if (start_q) begin
          besta_x_d    = scan_best_x;
          besta_y_d    = scan_best_y;
          besta_proj_d = scan_best_proj;
        end
        if (scan_done) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (res_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      a_vx_q       <= '0;
      a_vy_q       <= '0;
      b_vx_q       <= '0;
      b_vy_q       <= '0;
      a_pos_x_q    <= '0;
      a_pos_y_q    <= '0;
      b_pos_x_q    <= '0;
      b_pos_y_q    <= '0;
      dir_x_q      <= '0;
      dir_y_q      <= '0;
      besta_x_q    <= '0;
      besta_y_q    <= '0;
      besta_proj_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      a_vx_q       <= a_vx_d;
      a_vy_q       <= a_vy_d;
      b_vx_q       <= b_vx_d;
      b_vy_q       <= b_vy_d;
      a_pos_x_q    <= a_pos_x_d;
      a_pos_y_q    <= a_pos_y_d;
      b_pos_x_q    <= b_pos_x_d;
      b_pos_y_q    <= b_pos_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      besta_x_q    <= besta_x_d;
      besta_y_q    <= besta_y_d;
      besta_proj_q <= besta_proj_d;
      cnt_q        <= cnt_d;
    end
  end

  // In OUT the scan is idle, so its registers hold B's result stably.
  always_comb begin
    req_ready = (state_q == IDLE);
    res_valid = (state_q == OUT);
    res_x     = '0;
    res_y     = '0;
    res_proj  = '0;
    if (state_q == OUT) begin
      res_x    = {besta_x_q[COORD_W-1], besta_x_q} - {scan_best_x[COORD_W-1], scan_best_x};
      res_y    = {besta_y_q[COORD_W-1], besta_y_q} - {scan_best_y[COORD_W-1], scan_best_y};
      res_proj = {besta_proj_q[PROJ_W-1], besta_proj_q}
               + {scan_best_proj[PROJ_W-1], scan_best_proj};
    end
  end

  assign query_cnt = cnt_q;

endmodule

// File: tb/tb_minkowski_support_ctrl.sv
module tb_minkowski_support_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [75:0] a_vx = '0, a_vy = '0, b_vx = '0, b_vy = '0;
  logic [18:0] a_pos_x = '0, a_pos_y = '0, b_pos_x = '0, b_pos_y = '0;
  logic [9:0]  dir_x = '0, dir_y = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [19:0] res_x, res_y;
  logic [29:0] res_proj;
  logic [15:0] query_cnt;

  minkowski_support_ctrl #(.NVERT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .a_vx(a_vx), .a_vy(a_vy), .a_pos_x(a_pos_x), .a_pos_y(a_pos_y),
    .b_vx(b_vx), .b_vy(b_vy), .b_pos_x(b_pos_x), .b_pos_y(b_pos_y),
    .dir_x(dir_x), .dir_y(dir_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_proj(res_proj),
    .query_cnt(query_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int p;
    int acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int last_hs = -100;

  // Shape description used by both the port driver and the reference model
  int ax[4], ay[4], bx[4], by[4];
  int apx, apy, bpx, bpy, dx, dy;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int satneg(input int d);
    return (d == -512) ? 511 : -d;
  endfunction

  // Reference: argmax of (v-pos).d over each shape, strict > so ties keep lowest index
  function automatic void model(output int ex, output int ey, output int ep);
    int ba_x, ba_y, ba_p, bb_x, bb_y, bb_p, p;
    int ndx, ndy;
    ndx = satneg(dx);
    ndy = satneg(dy);
    ba_x = 0; ba_y = 0; ba_p = 0; bb_x = 0; bb_y = 0; bb_p = 0;
    for (int i = 0; i < 4; i++) begin
      p = (ax[i] - apx) * dx + (ay[i] - apy) * dy;
      if (i == 0 || p > ba_p) begin ba_x = ax[i]; ba_y = ay[i]; ba_p = p; end
      p = (bx[i] - bpx) * ndx + (by[i] - bpy) * ndy;
      if (i == 0 || p > bb_p) begin bb_x = bx[i]; bb_y = by[i]; bb_p = p; end
    end
    ex = ba_x - bb_x;
    ey = ba_y - bb_y;
    ep = ba_p + bb_p;
  endfunction

  task automatic drive_ports();
    for (int i = 0; i < 4; i++) begin
      a_vx[i*19 +: 19] = 19'(ax[i]);
      a_vy[i*19 +: 19] = 19'(ay[i]);
      b_vx[i*19 +: 19] = 19'(bx[i]);
      b_vy[i*19 +: 19] = 19'(by[i]);
    end
    a_pos_x = 19'(apx); a_pos_y = 19'(apy);
    b_pos_x = 19'(bpx); b_pos_y = 19'(bpy);
    dir_x = 10'(dx); dir_y = 10'(dy);
  endtask

  task automatic scramble_ports();
    a_vx = 76'({$urandom(), $urandom(), $urandom()});
    a_vy = 76'({$urandom(), $urandom(), $urandom()});
    b_vx = 76'({$urandom(), $urandom(), $urandom()});
    b_vy = 76'({$urandom(), $urandom(), $urandom()});
    a_pos_x = 19'($urandom()); a_pos_y = 19'($urandom());
    b_pos_x = 19'($urandom()); b_pos_y = 19'($urandom());
    dir_x = 10'($urandom()); dir_y = 10'($urandom());
  endtask

  task automatic load_common();
    ax = '{0, 10, 10, 0};   ay = '{0, 0, 10, 10}; apx = 5;  apy = 5;
    bx = '{20, 30, 30, 20}; by = '{0, 0, 10, 10}; bpx = 25; bpy = 5;
  endtask

  task automatic load_random();
    for (int i = 0; i < 4; i++) begin
      ax[i] = int'($urandom_range(0, 8000)) - 4000;
      ay[i] = int'($urandom_range(0, 8000)) - 4000;
      bx[i] = int'($urandom_range(0, 8000)) - 4000;
      by[i] = int'($urandom_range(0, 8000)) - 4000;
    end
    apx = int'($urandom_range(0, 8000)) - 4000;
    apy = int'($urandom_range(0, 8000)) - 4000;
    bpx = int'($urandom_range(0, 8000)) - 4000;
    bpy = int'($urandom_range(0, 8000)) - 4000;
    dx = ($urandom_range(0, 7) == 0) ? -512 : int'($urandom_range(0, 1023)) - 512;
    dy = int'($urandom_range(0, 1023)) - 512;
  endtask

  // Called at posedge+1. Holds req_valid until accepted, pushes the expected
  // result, then drops req_valid and garbles the inputs.
  task automatic run_query(input bit use_exp, input int cx, input int cy, input int cp,
                           input bit chk_gap, input bit rand_bp, output int acc);
    int ex, ey, ep, n;
    if (use_exp) begin ex = cx; ey = cy; ep = cp; end
    else model(ex, ey, ep);
    drive_ports();
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 300) begin
      if (rand_bp) res_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    sb.push_back('{ex, ey, ep, acc});
    if (chk_gap) chk("accept_after_handshake", acc, last_hs + 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble_ports();
  endtask

  // Monitor / scoreboard
  logic [15:0] exp_cnt = '0;
  bit          cnt_chk = 1'b0, prev_valid = 1'b0, prev_hold = 1'b0;
  logic [19:0] prev_x, prev_y;
  logic [29:0] prev_p;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_hold  = 1'b0;
      exp_cnt    = '0;
      cnt_chk    = 1'b0;
    end else begin
      if (cnt_chk) begin
        chk("query_cnt", query_cnt, exp_cnt);
        cnt_chk = 1'b0;
      end
      if (res_valid) begin
        chk("req_ready_in_out", req_ready, 0);
        if (!prev_valid) begin
          if (sb.size() == 0) chk("unexpected_res_valid", 1, 0);
          else chk("latency", cyc - sb[0].acc, 9);
        end else if (prev_hold) begin
          chk("hold_res_x", res_x, prev_x);
          chk("hold_res_y", res_y, prev_y);
          chk("hold_res_proj", res_proj, prev_p);
        end
        if (res_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_handshake", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("res_x", $signed(res_x), e.x);
            chk("res_y", $signed(res_y), e.y);
            chk("res_proj", $signed(res_proj), e.p);
          end
          exp_cnt = exp_cnt + 16'd1;
          cnt_chk = 1'b1;
          last_hs = cyc;
        end
      end
      if (req_valid && req_ready) accepts++;
      prev_valid = res_valid;
      prev_hold  = res_valid && !res_ready;
      prev_x = res_x;
      prev_y = res_y;
      prev_p = res_proj;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, acc2, a0, n;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_x", res_x, 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_res_proj", res_proj, 0);
    chk("rst_query_cnt", query_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1-3: directed shapes, including zero and most-negative direction
    res_ready = 1'b1;
    load_common(); dx = 1; dy = 0;
    run_query(1, -10, 0, 10, 0, 0, acc);
    load_common(); dx = 0; dy = 0;
    run_query(1, -20, 0, 0, 0, 0, acc);
    load_common(); dx = -512; dy = 0;
    run_query(1, -30, 0, 5115, 0, 0, acc);
    drain();
    chk("query_cnt_after_3", query_cnt, 3);

    // 4: backpressure with req_valid pulses while OUT is held
    res_ready = 1'b0;
    load_common(); dx = 1; dy = 0;
    run_query(1, -10, 0, 10, 0, 0, acc);
    n = 0;
    while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_res_valid_seen", res_valid, 1);
    a0 = accepts;
    repeat (5) begin
      req_valid = ~req_valid;
      scramble_ports();
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("bp_no_extra_accept", accepts, a0);
    chk("bp_still_valid", res_valid, 1);
    res_ready = 1'b1;
    load_common(); dx = 0; dy = 1;
    run_query(0, 0, 0, 0, 1, 0, acc);
    drain();

    // 5: reset in the middle of SCAN_B discards the query
    load_random();
    run_query(0, 0, 0, 0, 0, 0, acc);
    n = 0;
    while (cyc != acc + 6 && n < 50) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_query_cnt", query_cnt, 0);
    chk("midrst_res_proj", res_proj, 0);
    load_common(); dx = 1; dy = 0;
    run_query(1, -10, 0, 10, 0, 0, acc);
    drain();

    // 6: back-to-back queries, inputs garbled after each acceptance
    load_random();
    run_query(0, 0, 0, 0, 0, 0, acc);
    load_random();
    run_query(0, 0, 0, 0, 0, 0, acc2);
    chk("b2b_gap", acc2 - acc, 10);
    drain();
    chk("b2b_query_cnt", query_cnt, 3);

    // Randomized shapes with random result backpressure
    repeat (25) begin
      load_random();
      run_query(0, 0, 0, 0, 0, 1, acc);
    end
    res_ready = 1'b1;
    drain();
    chk("final_query_cnt", query_cnt, 28);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
